memshare_l1pa_sched: RTL and testbench

// Session scheduler in front of memShare_rfmu / L1PA register file. Accepts one GP2 request-flag set per

---
 rtl/memshare_l1pa_sched.sv | 138 +++++++++++++
 tb/tb_memshare_l1pa_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/memshare_l1pa_sched.sv
// memshare_l1pa_sched
//   Session scheduler in front of the RFMU / L1PA register file. It accepts one
//   request-flag set per session and serves the pending flags lowest index
//   first, one round per flag. Each round drives the pending vector to the
//   RFMU and waits out the feedback latency. It then forwards the fed-back
//   shift to the L1PA as a one-cycle strobe. A session ends on the
//   last-pattern indication (isGtr), on an emptied vector, or on the round
//   watchdog.
// Ports
//   sys_clk, rst        clock, asynchronous active-high reset
//   rqst_valid_i/flag_i new request set; accepted only while rqst_ready_o=1
//   rfmu_rqst_o         pending flags to the RFMU (0 outside a round)
//   rfmu_shift_i/isGtr_i RFMU feedback, sampled once per round
//   l1pa_shift_o/_valid_o registered shift command + one-cycle qualifier
//   busy_o, done_o, err_o session in progress / normal end / watchdog abort
module memshare_l1pa_sched #(
  parameter int RQST_BITWIDTH       = 5,
  parameter int L1PA_SHIFT_BITWIDTH = $clog2(RQST_BITWIDTH),
  parameter int FB_LATENCY          = 2,
  parameter int MAX_ROUNDS          = RQST_BITWIDTH
) (
  input  logic                           sys_clk,
  input  logic                           rst,
  input  logic                           rqst_valid_i,
  input  logic [RQST_BITWIDTH-1:0]       rqst_flag_i,
  output logic                           rqst_ready_o,
  output logic [RQST_BITWIDTH-1:0]       rfmu_rqst_o,
  input  logic [L1PA_SHIFT_BITWIDTH-1:0] rfmu_shift_i,
  input  logic                           rfmu_isGtr_i,
  output logic [L1PA_SHIFT_BITWIDTH-1:0] l1pa_shift_o,
  output logic                           l1pa_shift_valid_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o
);

  localparam int WCNT_W  = $clog2(FB_LATENCY + 1);
  localparam int ROUND_W = $clog2(MAX_ROUNDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_ERR} state_t;

  state_t                           state_q, state_d;
  logic [RQST_BITWIDTH-1:0]         pending_q, pending_d;
  logic [WCNT_W-1:0]                wcnt_q, wcnt_d;
  logic [ROUND_W-1:0]               round_q, round_d;
  logic [L1PA_SHIFT_BITWIDTH-1:0]   shift_q, shift_d;
  logic                             svld_q, svld_d;
  logic                             done_q, done_d;
  logic                             err_q, err_d;

  logic [RQST_BITWIDTH-1:0]         pending_clr;
  logic [ROUND_W-1:0]               round_inc;
  logic                             sample;

  // x & (x-1) drops the lowest set bit: the flag just served.
  assign pending_clr = pending_q & (pending_q - RQST_BITWIDTH'(1));
  assign round_inc   = round_q + ROUND_W'(1);
  // Last cycle of the feedback wait; only here is the RFMU feedback valid.
  assign sample      = (wcnt_q == WCNT_W'(FB_LATENCY - 1));

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    wcnt_d    = wcnt_q;
    round_d   = round_q;
    shift_d   = shift_q;
    svld_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rqst_valid_i) begin
          pending_d = rqst_flag_i;
          round_d   = '0;
          wcnt_d    = '0;
          // An empty set finishes without touching the RFMU.
          state_d   = (rqst_flag_i == '0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (sample) begin
          shift_d   = rfmu_shift_i;
          svld_d    = 1'b1;
          pending_d = pending_clr;
          round_d   = round_inc;
          wcnt_d    = '0;
          // Normal completion wins over the watchdog on the final round.
          if (rfmu_isGtr_i || (pending_clr == '0)) state_d = S_DONE;
          else if (round_inc == ROUND_W'(MAX_ROUNDS)) state_d = S_ERR;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      S_DONE: begin
        done_d    = 1'b1;
        pending_d = '0;
        state_d   = S_IDLE;
      end
      S_ERR: begin
        err_d     = 1'b1;
        pending_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      wcnt_q    <= '0;
      round_q   <= '0;
      shift_q   <= '0;
      svld_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      wcnt_q    <= wcnt_d;
      round_q   <= round_d;
      shift_q   <= shift_d;
      svld_q    <= svld_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign rqst_ready_o       = (state_q == S_IDLE);
  assign busy_o             = (state_q != S_IDLE);
  assign rfmu_rqst_o        = (state_q == S_WAIT) ? pending_q : '0;
  assign l1pa_shift_o       = shift_q;
  assign l1pa_shift_valid_o = svld_q;
  assign done_o             = done_q;
  assign err_o              = err_q;

endmodule

// File: tb/tb_memshare_l1pa_sched.sv
// Bench for memshare_l1pa_sched. Three instances:
//   dut 0: defaults (FB_LATENCY=2, MAX_ROUNDS=5)
//   dut 1: MAX_ROUNDS=2 (watchdog reachable)
//   dut 2: FB_LATENCY=1 (strobe every cycle)
// Cycle j below counts negedges after the accept edge (j=0 is the first cycle
// after acceptance).
module tb_memshare_l1pa_sched;

  logic sys_clk = 1'b0;
  logic rst;
  always #5 sys_clk = ~sys_clk;

  logic [2:0]      valid_i, isgtr_i, ready_o, sv_o, busy_o, done_o, err_o;
  logic [2:0][4:0] flag_i, rqst_o;
  logic [2:0][2:0] shift_i, shift_o;

  memshare_l1pa_sched #(.FB_LATENCY(2), .MAX_ROUNDS(5)) u_d0 (
    .sys_clk(sys_clk), .rst(rst), .rqst_valid_i(valid_i[0]), .rqst_flag_i(flag_i[0]),
    .rqst_ready_o(ready_o[0]), .rfmu_rqst_o(rqst_o[0]), .rfmu_shift_i(shift_i[0]),
    .rfmu_isGtr_i(isgtr_i[0]), .l1pa_shift_o(shift_o[0]), .l1pa_shift_valid_o(sv_o[0]),
    .busy_o(busy_o[0]), .done_o(done_o[0]), .err_o(err_o[0]));

  memshare_l1pa_sched #(.FB_LATENCY(2), .MAX_ROUNDS(2)) u_d1 (
    .sys_clk(sys_clk), .rst(rst), .rqst_valid_i(valid_i[1]), .rqst_flag_i(flag_i[1]),
    .rqst_ready_o(ready_o[1]), .rfmu_rqst_o(rqst_o[1]), .rfmu_shift_i(shift_i[1]),
    .rfmu_isGtr_i(isgtr_i[1]), .l1pa_shift_o(shift_o[1]), .l1pa_shift_valid_o(sv_o[1]),
    .busy_o(busy_o[1]), .done_o(done_o[1]), .err_o(err_o[1]));

  memshare_l1pa_sched #(.FB_LATENCY(1), .MAX_ROUNDS(5)) u_d2 (
    .sys_clk(sys_clk), .rst(rst), .rqst_valid_i(valid_i[2]), .rqst_flag_i(flag_i[2]),
    .rqst_ready_o(ready_o[2]), .rfmu_rqst_o(rqst_o[2]), .rfmu_shift_i(shift_i[2]),
    .rfmu_isGtr_i(isgtr_i[2]), .l1pa_shift_o(shift_o[2]), .l1pa_shift_valid_o(sv_o[2]),
    .busy_o(busy_o[2]), .done_o(done_o[2]), .err_o(err_o[2]));

  int checks   = 0;
  int failures = 0;
  int exp_shift [3];

  function automatic int fb_of(input int d);
    return (d == 2) ? 1 : 2;
  endfunction

  function automatic int mr_of(input int d);
    return (d == 1) ? 2 : 5;
  endfunction

  // Flag set with its k lowest set bits already served.
  function automatic logic [4:0] pend_after(input logic [4:0] f, input int k);
    logic [4:0] p;
    int removed;
    p = f;
    removed = 0;
    for (int b = 0; b < 5; b++)
      if (f[b] && removed < k) begin
        p[b] = 1'b0;
        removed++;
      end
    return p;
  endfunction

  task automatic chk(input string nm, input int d, input int j, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut=%0d cyc=%0d got=%0d exp=%0d", nm, d, j, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm, input int d);
    chk({nm, "_ready"}, d, -1, int'(ready_o[d]), 1);
    chk({nm, "_busy"},  d, -1, int'(busy_o[d]), 0);
    chk({nm, "_rqst"},  d, -1, int'(rqst_o[d]), 0);
    chk({nm, "_sv"},    d, -1, int'(sv_o[d]), 0);
    chk({nm, "_shift"}, d, -1, int'(shift_o[d]), exp_shift[d]);
    chk({nm, "_done"},  d, -1, int'(done_o[d]), 0);
    chk({nm, "_err"},   d, -1, int'(err_o[d]), 0);
  endtask

  // One complete session on dut d, checked cycle by cycle against a timeline
  // derived from the flag count, the isGtr mask and the round watchdog.
  // Called at a negedge with the dut idle; returns at the negedge of the
  // done/err cycle with the dut idle again.
  task automatic session(input int d, input logic [4:0] f, input int gmask, input bit hold,
                         output int n_strb, output int n_done, output int n_err);
    int fb, mr, pc, nr, t;
    bit is_err, ev;
    logic [4:0] er;
    logic [2:0] sh [8];
    fb = fb_of(d);
    mr = mr_of(d);
    pc = $countones(f);
    for (int r = 0; r < 8; r++) sh[r] = 3'($urandom_range(0, 7));
    nr = 0;
    is_err = 1'b0;
    if (pc != 0)
      for (int r = 0; r < 8; r++) begin
        if (gmask[r] || r == pc - 1) begin nr = r + 1; break; end
        if (r + 1 == mr) begin nr = r + 1; is_err = 1'b1; break; end
      end
    t = nr * fb;
    n_strb = 0; n_done = 0; n_err = 0;
    chk("ready_pre", d, -1, int'(ready_o[d]), 1);
    valid_i[d] = 1'b1;
    flag_i[d]  = f;
    shift_i[d] = 3'($urandom);
    isgtr_i[d] = 1'($urandom);
    @(posedge sys_clk);
    for (int j = 0; j <= t + 1; j++) begin
      @(negedge sys_clk);
      ev = (nr > 0) && (j > 0) && (j % fb == 0) && (j <= t);
      if (ev) exp_shift[d] = int'(sh[j / fb - 1]);
      er = (j < t) ? pend_after(f, j / fb) : 5'b0;
      chk("ready", d, j, int'(ready_o[d]), int'(j == t + 1));
      chk("busy",  d, j, int'(busy_o[d]),  int'(j <= t));
      chk("rqst",  d, j, int'(rqst_o[d]),  int'(er));
      chk("sv",    d, j, int'(sv_o[d]),    int'(ev));
      chk("shift", d, j, int'(shift_o[d]), exp_shift[d]);
      chk("done",  d, j, int'(done_o[d]),  int'((j == t + 1) && !is_err));
      chk("err",   d, j, int'(err_o[d]),   int'((j == t + 1) && is_err));
      n_strb += int'(sv_o[d]);
      n_done += int'(done_o[d]);
      n_err  += int'(err_o[d]);
      // A held request with other flags must not disturb the session.
      if (hold && j < t + 1) begin
        valid_i[d] = 1'b1;
        flag_i[d]  = 5'($urandom);
      end else begin
        valid_i[d] = 1'b0;
      end
      // Real feedback only in the sample cycle; noise elsewhere.
      if (j < t && (j % fb) == fb - 1) begin
        shift_i[d] = sh[j / fb];
        isgtr_i[d] = gmask[j / fb];
      end else begin
        shift_i[d] = 3'($urandom);
        isgtr_i[d] = 1'($urandom);
      end
    end
  endtask

  typedef struct {
    int         d;
    logic [4:0] flag;
    int         gmask;
    bit         hold;
    int         exp_strb;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int ns, nd, ne;
    tbl[0] = '{0, 5'b10110, 4, 0, 3, 1, 0};
    tbl[1] = '{0, 5'b01000, 0, 0, 1, 1, 0};
    tbl[2] = '{0, 5'b00000, 0, 0, 0, 1, 0};
    tbl[3] = '{1, 5'b11111, 0, 0, 2, 0, 1};
    tbl[4] = '{1, 5'b11111, 2, 0, 2, 1, 0};
    tbl[5] = '{0, 5'b11111, 0, 1, 5, 1, 0};
    tbl[6] = '{0, 5'b11111, 1, 0, 1, 1, 0};
    tbl[7] = '{2, 5'b10101, 0, 1, 3, 1, 0};
    tbl[8] = '{2, 5'b00011, 0, 1, 2, 1, 0};
    tbl[9] = '{1, 5'b00001, 0, 0, 1, 1, 0};

    rst = 1'b1;
    valid_i = '0; isgtr_i = '0; flag_i = '0; shift_i = '0;
    for (int d = 0; d < 3; d++) exp_shift[d] = 0;
    @(negedge sys_clk);
    for (int d = 0; d < 3; d++) chk_idle("reset", d);
    rst = 1'b0;
    @(negedge sys_clk);

    for (int i = 0; i < 10; i++) begin
      session(tbl[i].d, tbl[i].flag, tbl[i].gmask, tbl[i].hold, ns, nd, ne);
      chk("tbl_strobes", tbl[i].d, i, ns, tbl[i].exp_strb);
      chk("tbl_done",    tbl[i].d, i, nd, tbl[i].exp_done);
      chk("tbl_err",     tbl[i].d, i, ne, tbl[i].exp_err);
    end

    // Reset in the middle of round 1 of a 10110 session on dut 0.
    @(negedge sys_clk);
    valid_i[0] = 1'b1;
    flag_i[0]  = 5'b10110;
    @(posedge sys_clk);
    @(negedge sys_clk);
    valid_i[0] = 1'b0;
    @(negedge sys_clk);
    shift_i[0] = 3'd5;
    isgtr_i[0] = 1'b0;
    @(negedge sys_clk);
    chk("mid_sv",    0, 2, int'(sv_o[0]), 1);
    chk("mid_shift", 0, 2, int'(shift_o[0]), 5);
    chk("mid_rqst",  0, 2, int'(rqst_o[0]), int'(5'b10100));
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) exp_shift[d] = 0;
    chk_idle("async_rst", 0);
    @(negedge sys_clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      chk_idle("post_rst", 0);
    end
    session(0, 5'b10110, 4, 0, ns, nd, ne);
    chk("post_rst_strobes", 0, -1, ns, 3);

    // Randomised sessions, sometimes back to back.
    for (int it = 0; it < 40; it++) begin
      int d, gm;
      logic [4:0] f;
      d  = $urandom_range(0, 2);
      f  = 5'($urandom);
      gm = int'($urandom & $urandom & 32'h1f);
      session(d, f, gm, 1'($urandom), ns, nd, ne);
      if ($urandom_range(0, 3) == 0) @(negedge sys_clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
